// File: rtl/nf_pkg.sv
// Shared AXI-Stream widths and buffer word layout for the network-function RX path.
package nf_pkg;

  localparam int unsigned AXIS_DATA_W = 64;
  localparam int unsigned AXIS_KEEP_W = 8;

  typedef struct packed {
    logic [AXIS_DATA_W-1:0] data;
    logic [AXIS_KEEP_W-1:0] keep;
    logic                   last;
  } ram_word_t;

  localparam int unsigned RAM_WORD_W = $bits(ram_word_t);

  typedef enum logic [1:0] {
    WR_SYNC,
    WR_IDLE,
    WR_RECV,
    WR_DROP
  } wr_state_t;

endpackage

// File: rtl/nf_sdp_ram.sv
// Simple dual-port RAM, one write port and one registered read port; maps onto block RAM.
module nf_sdp_ram #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 73
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // rdata holds its value while re is low; the read pipeline relies on that to stall.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/nf_rx_frame_buffer.sv
// Store-and-forward RX buffer: frames are committed only on a good-FCS tlast, then replayed.
module nf_rx_frame_buffer
  import nf_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                   clk156,
  input  logic                   reset_n,
  input  logic [AXIS_DATA_W-1:0] s_axis_rx_tdata,
  input  logic [AXIS_KEEP_W-1:0] s_axis_rx_tkeep,
  input  logic                   s_axis_rx_tvalid,
  input  logic                   s_axis_rx_tlast,
  input  logic                   s_axis_rx_tuser,
  output logic [AXIS_DATA_W-1:0] m_axis_rx_tdata,
  output logic [AXIS_KEEP_W-1:0] m_axis_rx_tkeep,
  output logic                   m_axis_rx_tvalid,
  output logic                   m_axis_rx_tlast,
  output logic                   m_axis_rx_tuser,
  input  logic                   m_axis_rx_tready,
  output logic [CNT_WIDTH-1:0]   frames_good,
  output logic [CNT_WIDTH-1:0]   frames_bad,
  output logic [CNT_WIDTH-1:0]   frames_ovf
);

  typedef logic [ADDR_WIDTH:0]  ptr_t;
  typedef logic [CNT_WIDTH-1:0] cnt_t;

  localparam ptr_t DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  wr_state_t state;
  ptr_t      wr_ptr, commit_ptr, rd_ptr, fill;
  logic      full, accepting, we;
  logic      avail, out_free, ram_vld, move, re;
  ram_word_t wword, rword;

  assign fill      = wr_ptr - rd_ptr;
  assign full      = (fill == DEPTH);
  assign accepting = (state == WR_IDLE) || (state == WR_RECV);
  assign we        = s_axis_rx_tvalid && accepting && !full;
  assign wword     = '{data: s_axis_rx_tdata, keep: s_axis_rx_tkeep, last: s_axis_rx_tlast};

  nf_sdp_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (RAM_WORD_W)
  ) u_ram (
    .clk   (clk156),
    .we    (we),
    .waddr (wr_ptr[ADDR_WIDTH-1:0]),
    .wdata (wword),
    .re    (re),
    .raddr (rd_ptr[ADDR_WIDTH-1:0]),
    .rdata (rword)
  );

  always_ff @(posedge clk156 or negedge reset_n) begin
    if (!reset_n) begin
      state       <= WR_SYNC;
      wr_ptr      <= '0;
      commit_ptr  <= '0;
      frames_good <= '0;
      frames_bad  <= '0;
      frames_ovf  <= '0;
    end else if (s_axis_rx_tvalid) begin
      case (state)
        WR_SYNC: if (s_axis_rx_tlast) state <= WR_IDLE;
        WR_IDLE, WR_RECV: begin
          if (full) begin
            wr_ptr <= commit_ptr;
            if (s_axis_rx_tlast) begin
              frames_ovf <= frames_ovf + cnt_t'(1);
              state      <= WR_IDLE;
            end else begin
              state <= WR_DROP;
            end
          end else if (s_axis_rx_tlast) begin
            if (s_axis_rx_tuser) begin
              wr_ptr      <= wr_ptr + ptr_t'(1);
              commit_ptr  <= wr_ptr + ptr_t'(1);
              frames_good <= frames_good + cnt_t'(1);
            end else begin
              wr_ptr     <= commit_ptr;
              frames_bad <= frames_bad + cnt_t'(1);
            end
            state <= WR_IDLE;
          end else begin
            wr_ptr <= wr_ptr + ptr_t'(1);
            state  <= WR_RECV;
          end
        end
        WR_DROP: if (s_axis_rx_tlast) begin
          frames_ovf <= frames_ovf + cnt_t'(1);
          state      <= WR_IDLE;
        end
        default: state <= WR_SYNC;
      endcase
    end
  end

  // Two-stage read pipe: RAM output stage (ram_vld) feeding the output register.
  // A new read is issued only when the RAM stage is empty or draining this cycle.
  assign avail    = (rd_ptr != commit_ptr);
  assign out_free = !m_axis_rx_tvalid || m_axis_rx_tready;
  assign move     = ram_vld && out_free;
  assign re       = avail && (!ram_vld || move);

  always_ff @(posedge clk156 or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr           <= '0;
      ram_vld          <= 1'b0;
      m_axis_rx_tdata  <= '0;
      m_axis_rx_tkeep  <= '0;
      m_axis_rx_tvalid <= 1'b0;
      m_axis_rx_tlast  <= 1'b0;
      m_axis_rx_tuser  <= 1'b0;
    end else begin
      if (re) rd_ptr <= rd_ptr + ptr_t'(1);
      ram_vld <= re || (ram_vld && !move);
      if (out_free) begin
        m_axis_rx_tvalid <= move;
        if (move) begin
          m_axis_rx_tdata <= rword.data;
          m_axis_rx_tkeep <= rword.keep;
          m_axis_rx_tlast <= rword.last;
          m_axis_rx_tuser <= rword.last;
        end
      end
    end
  end

endmodule

// File: tb/tb_nf_rx_frame_buffer.sv
// Bench for nf_rx_frame_buffer: directed frame table, corner sequences and a random phase.
`timescale 1ns/1ps
module tb_nf_rx_frame_buffer;

  logic        clk156 = 1'b0;
  logic        reset_n = 1'b0;
  logic [63:0] s_tdata = '0;
  logic [7:0]  s_tkeep = '0;
  logic        s_tvalid = 1'b0, s_tlast = 1'b0, s_tuser = 1'b0;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic        m_tvalid, m_tlast, m_tuser;
  logic        m_tready = 1'b1;
  logic [31:0] frames_good, frames_bad, frames_ovf;

  nf_rx_frame_buffer #(.ADDR_WIDTH(4), .CNT_WIDTH(32)) dut (
    .clk156           (clk156),
    .reset_n          (reset_n),
    .s_axis_rx_tdata  (s_tdata),
    .s_axis_rx_tkeep  (s_tkeep),
    .s_axis_rx_tvalid (s_tvalid),
    .s_axis_rx_tlast  (s_tlast),
    .s_axis_rx_tuser  (s_tuser),
    .m_axis_rx_tdata  (m_tdata),
    .m_axis_rx_tkeep  (m_tkeep),
    .m_axis_rx_tvalid (m_tvalid),
    .m_axis_rx_tlast  (m_tlast),
    .m_axis_rx_tuser  (m_tuser),
    .m_axis_rx_tready (m_tready),
    .frames_good      (frames_good),
    .frames_bad       (frames_bad),
    .frames_ovf       (frames_ovf)
  );

  always #3 clk156 = ~clk156;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } exp_t;

  typedef struct {
    int unsigned len;
    bit          user;
    logic [63:0] base;
    logic [7:0]  lastkeep;
    int unsigned exp_good;
    int unsigned exp_bad;
  } vec_t;

  exp_t        exp_q[$];
  int          checks = 0, errors = 0;
  int unsigned out_count = 0;
  int unsigned m_good = 0, m_bad = 0, m_ovf = 0;
  int          ready_mode = 0;  // 0 manual, 1 toggle, 2 random

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitor: scoreboard on handshakes plus AXI-Stream hold check while stalled.
  logic        prev_stall = 1'b0;
  logic [63:0] prev_d;
  logic [7:0]  prev_k;
  logic        prev_l;
  always @(negedge clk156) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", {63'd0, m_tvalid}, 64'd1);
        chk("hold_data", m_tdata, prev_d);
        chk("hold_keep", {56'd0, m_tkeep}, {56'd0, prev_k});
        chk("hold_last", {63'd0, m_tlast}, {63'd0, prev_l});
      end
      if (m_tvalid && m_tready) begin
        out_count++;
        if (exp_q.size() == 0) begin
          chk("unexpected_word", m_tdata, 64'hx);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_data", m_tdata, e.d);
          chk("out_keep", {56'd0, m_tkeep}, {56'd0, e.k});
          chk("out_last", {63'd0, m_tlast}, {63'd0, e.l});
          chk("out_user", {63'd0, m_tuser}, {63'd0, e.l});
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_d = m_tdata;
      prev_k = m_tkeep;
      prev_l = m_tlast;
    end
  end

  always begin
    @(posedge clk156);
    #1;
    if (ready_mode == 1) m_tready = ~m_tready;
    else if (ready_mode == 2) m_tready = 1'($urandom_range(0, 1));
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk156);
      #1;
    end
  endtask

  task automatic put(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
    s_tdata = d; s_tkeep = k; s_tlast = l; s_tuser = u; s_tvalid = 1'b1;
    @(posedge clk156);
    #1;
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
  endtask

  // Non-last words carry the inverse tuser so that tuser is proven to matter only on tlast.
  task automatic send_frame(input int unsigned len, input bit user, input logic [63:0] base,
                            input logic [7:0] lastkeep, input logic [31:0] gaps);
    for (int unsigned i = 0; i < len; i++) begin
      if (gaps[i]) idle(1);
      put(base + 64'(i), (i == len - 1) ? lastkeep : 8'hff, i == len - 1,
          (i == len - 1) ? user : !user);
    end
  endtask

  task automatic model_good(input int unsigned len, input logic [63:0] base, input logic [7:0] lastkeep);
    for (int unsigned i = 0; i < len; i++)
      exp_q.push_back('{d: base + 64'(i), k: (i == len - 1) ? lastkeep : 8'hff, l: i == len - 1});
    m_good++;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk156);
      #1;
      n++;
    end
    chk(name, 64'(exp_q.size()), 64'd0);
    idle(3);
  endtask

  vec_t        vecs[5];
  int unsigned oc;

  initial begin
    vecs[0] = '{3, 1'b1, 64'h1111_0000_0000_0000, 8'h07, 2, 1};
    vecs[1] = '{2, 1'b0, 64'h2222_0000_0000_0000, 8'hff, 2, 2};
    vecs[2] = '{4, 1'b1, 64'h3333_0000_0000_0000, 8'h01, 3, 2};
    vecs[3] = '{1, 1'b1, 64'h4444_0000_0000_0000, 8'h3f, 4, 2};
    vecs[4] = '{1, 1'b0, 64'h5555_0000_0000_0000, 8'hff, 4, 3};

    @(posedge clk156);
    #1;
    chk("rst_tvalid", {63'd0, m_tvalid}, 64'd0);
    chk("rst_tdata", m_tdata, 64'd0);
    chk("rst_tlast", {62'd0, m_tlast, m_tuser}, 64'd0);
    chk("rst_counters", {32'd0, frames_good | frames_bad | frames_ovf}, 64'd0);

    // Reset released mid-frame: the tail must be swallowed by SYNC.
    put(64'haaaa_0000, 8'hff, 1'b0, 1'b0);
    reset_n = 1'b1;
    put(64'haaaa_0001, 8'hff, 1'b0, 1'b0);
    put(64'haaaa_0002, 8'hff, 1'b0, 1'b0);
    put(64'haaaa_0003, 8'hff, 1'b1, 1'b1);
    idle(6);
    chk("sync_good", 64'(frames_good), 64'd0);
    chk("sync_bad_ovf", 64'(frames_bad | frames_ovf), 64'd0);
    chk("sync_no_output", 64'(out_count), 64'd0);

    model_good(5, 64'hf00f_0000_d066_f00d, 8'h0f);
    send_frame(5, 1'b1, 64'hf00f_0000_d066_f00d, 8'h0f, 32'h0);
    wait_drain("drain_first");
    chk("first_good", 64'(frames_good), 64'd1);

    oc = out_count;
    send_frame(5, 1'b0, 64'hbad0_0000, 8'hff, 32'h10);
    m_bad++;
    idle(6);
    chk("bad_count", 64'(frames_bad), 64'd1);
    chk("bad_no_output", 64'(out_count - oc), 64'd0);

    foreach (vecs[i]) begin
      if (vecs[i].user) model_good(vecs[i].len, vecs[i].base, vecs[i].lastkeep);
      else m_bad++;
      send_frame(vecs[i].len, vecs[i].user, vecs[i].base, vecs[i].lastkeep, 32'h0);
      idle(2);
      chk("tbl_good", 64'(frames_good), 64'(vecs[i].exp_good));
      chk("tbl_bad", 64'(frames_bad), 64'(vecs[i].exp_bad));
    end
    wait_drain("drain_table");

    // Overflow with a 16-word buffer and the sink stalled.
    m_tready = 1'b0;
    oc = out_count;
    model_good(10, 64'h0f10_0000, 8'hff);
    send_frame(10, 1'b1, 64'h0f10_0000, 8'hff, 32'h0);
    send_frame(10, 1'b1, 64'h0f20_0000, 8'hff, 32'h0);
    m_ovf++;
    idle(2);
    chk("ovf_count1", 64'(frames_ovf), 64'd1);
    chk("ovf_good", 64'(frames_good), 64'(m_good));
    m_tready = 1'b1;
    wait_drain("drain_ovf");
    chk("ovf_out_words", 64'(out_count - oc), 64'd10);
    oc = out_count;
    send_frame(20, 1'b1, 64'h0f30_0000, 8'hff, 32'h0);
    m_ovf++;
    idle(8);
    chk("ovf_count2", 64'(frames_ovf), 64'd2);
    chk("ovf_long_no_output", 64'(out_count - oc), 64'd0);

    oc = out_count;
    ready_mode = 1;
    model_good(6, 64'hb00b_0000, 8'h1f);
    send_frame(6, 1'b1, 64'hb00b_0000, 8'h1f, 32'h0);
    wait_drain("drain_bp");
    ready_mode = 0;
    m_tready = 1'b1;
    chk("bp_words", 64'(out_count - oc), 64'd6);

    // Single-word frame latency: tlast accepted at edge N, tvalid at edge N+2.
    idle(4);
    model_good(1, 64'h1a7e_0001, 8'h01);
    put(64'h1a7e_0001, 8'h01, 1'b1, 1'b1);
    chk("lat_n", {63'd0, m_tvalid}, 64'd0);
    idle(1);
    chk("lat_n1", {63'd0, m_tvalid}, 64'd0);
    idle(1);
    chk("lat_n2_valid", {61'd0, m_tvalid, m_tlast, m_tuser}, 64'h7);
    wait_drain("drain_lat");

    ready_mode = 2;
    for (int f = 0; f < 60; f++) begin
      int unsigned len, n;
      bit          good;
      logic [63:0] base;
      logic [7:0]  lk;
      logic [31:0] gaps;
      n = 0;
      while (exp_q.size() > 4 && n < 200) begin
        idle(1);
        n++;
      end
      len  = $urandom_range(1, 6);
      good = 1'($urandom_range(0, 2) != 0);
      base = {$urandom, $urandom};
      lk   = 8'($urandom_range(1, 255));
      gaps = $urandom & $urandom;
      if (good) model_good(len, base, lk);
      else m_bad++;
      send_frame(len, good, base, lk, gaps);
    end
    wait_drain("drain_rand");
    ready_mode = 0;
    m_tready = 1'b1;
    chk("final_good", 64'(frames_good), 64'(m_good));
    chk("final_bad", 64'(frames_bad), 64'(m_bad));
    chk("final_ovf", 64'(frames_ovf), 64'(m_ovf));

    // Asynchronous reset while a word is held on the output.
    m_tready = 1'b0;
    model_good(3, 64'hdead_0000, 8'hff);
    send_frame(3, 1'b1, 64'hdead_0000, 8'hff, 32'h0);
    idle(4);
    chk("pre_reset_hold", {63'd0, m_tvalid}, 64'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_rst_valid", {63'd0, m_tvalid}, 64'd0);
    chk("async_rst_data", m_tdata, 64'd0);
    chk("async_rst_good", 64'(frames_good), 64'd0);
    exp_q.delete();
    idle(2);
    reset_n = 1'b1;
    m_tready = 1'b1;
    oc = out_count;
    idle(6);
    chk("post_reset_empty", 64'(out_count - oc), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
